// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - note codes, period bands and read-FSM state for the mic tone detector
package audio_pkg;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_C4   = 3'd1;
  localparam logic [2:0] NOTE_EB4  = 3'd2;
  localparam logic [2:0] NOTE_F4   = 3'd3;
  localparam logic [2:0] NOTE_G4   = 3'd4;
  localparam logic [2:0] NOTE_AB4  = 3'd5;
  localparam logic [2:0] NOTE_BB4  = 3'd6;
  localparam logic [2:0] NOTE_C5   = 3'd7;

  // Inclusive period bands in samples (48 kHz sampling of the melody notes)
  localparam logic [11:0] C4_LO  = 12'd170;
  localparam logic [11:0] C4_HI  = 12'd195;
  localparam logic [11:0] EB4_LO = 12'd147;
  localparam logic [11:0] EB4_HI = 12'd169;
  localparam logic [11:0] F4_LO  = 12'd131;
  localparam logic [11:0] F4_HI  = 12'd146;
  localparam logic [11:0] G4_LO  = 12'd120;
  localparam logic [11:0] G4_HI  = 12'd130;
  localparam logic [11:0] AB4_LO = 12'd110;
  localparam logic [11:0] AB4_HI = 12'd119;
  localparam logic [11:0] BB4_LO = 12'd98;
  localparam logic [11:0] BB4_HI = 12'd109;
  localparam logic [11:0] C5_LO  = 12'd87;
  localparam logic [11:0] C5_HI  = 12'd97;

  typedef enum logic [1:0] {IDLE, READ, GAP} rd_state_t;

endpackage

// File: rtl/note_classifier.sv
// rtl/note_classifier.sv - combinational period-to-note lookup
module note_classifier
  import audio_pkg::*;
(
  input  logic [11:0] i_period,
  output logic [2:0]  o_class
);

  always_comb begin
    o_class = NOTE_NONE;
    if (i_period >= C4_LO && i_period <= C4_HI)
      o_class = NOTE_C4;
    else if (i_period >= EB4_LO && i_period <= EB4_HI)
      o_class = NOTE_EB4;
    else if (i_period >= F4_LO && i_period <= F4_HI)
      o_class = NOTE_F4;
    else if (i_period >= G4_LO && i_period <= G4_HI)
      o_class = NOTE_G4;
    else if (i_period >= AB4_LO && i_period <= AB4_HI)
      o_class = NOTE_AB4;
    else if (i_period >= BB4_LO && i_period <= BB4_HI)
      o_class = NOTE_BB4;
    else if (i_period >= C5_LO && i_period <= C5_HI)
      o_class = NOTE_C5;
  end

endmodule

// File: rtl/mic_tone_detector.sv
// rtl/mic_tone_detector.sv - mic FIFO reader, L/R mix, hysteresis period meter and note classifier
// Optional DC-removal stage after the mix: define MIC_TONE_DET_DC_BLOCK_EN.
module mic_tone_detector
  import audio_pkg::*;
#(
  parameter logic signed [31:0] THRESH       = 32'sd1_000_000,
  parameter int                 MAX_PERIOD   = 400,
  parameter int                 STABLE_COUNT = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic        period_valid,
  output logic [11:0] period_samples,
  output logic [2:0]  note_index,
  output logic        note_valid
);

  localparam logic signed [31:0] L_NEG_THRESH = -THRESH;
  localparam logic [11:0]        L_MAX        = 12'(MAX_PERIOD);
  localparam logic [11:0]        L_MAX_M1     = 12'(MAX_PERIOD - 1);
  localparam logic [7:0]         L_STABLE     = 8'(STABLE_COUNT);

  rd_state_t          r_state;
  logic               r_read;
  logic signed [31:0] r_mono;
  logic               r_mono_vld;
  logic signed [32:0] w_sum;
  logic signed [31:0] w_x;
  logic               w_x_vld;

  // GAP gives the FIFO's empty flag a cycle to settle after a pop
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && audio_in_available) begin
            r_state <= READ;
            r_read  <= 1'b1;
          end
        end
        READ: begin
          r_state <= GAP;
          r_read  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  assign w_sum = $signed({left_channel_audio_in[31], left_channel_audio_in})
               + $signed({right_channel_audio_in[31], right_channel_audio_in});

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_mono     <= '0;
      r_mono_vld <= 1'b0;
    end else begin
      r_mono_vld <= (r_state == READ);
      if (r_state == READ)
        r_mono <= 32'(w_sum >>> 1);
    end
  end

`ifdef MIC_TONE_DET_DC_BLOCK_EN
  logic signed [31:0] r_avg;
  logic signed [31:0] r_dc;
  logic               r_dc_vld;
  logic signed [31:0] w_diff;

  assign w_diff = r_mono - r_avg;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_avg    <= '0;
      r_dc     <= '0;
      r_dc_vld <= 1'b0;
    end else begin
      r_dc_vld <= r_mono_vld;
      if (r_mono_vld) begin
        r_avg <= r_avg + (w_diff >>> 8);
        r_dc  <= w_diff;
      end
    end
  end

  assign w_x     = r_dc;
  assign w_x_vld = r_dc_vld;
`else
  assign w_x     = r_mono;
  assign w_x_vld = r_mono_vld;
`endif

  logic        r_pos;
  logic        r_armed;
  logic [11:0] r_cnt;
  logic [7:0]  r_stable;
  logic        r_pv;
  logic [11:0] r_ps;
  logic [2:0]  r_note;
  logic        r_nv;
  logic        w_pos_nxt;
  logic        w_rise;
  logic [11:0] w_period;
  logic [2:0]  w_class;
  logic [7:0]  w_stable_nxt;

  assign w_pos_nxt = (w_x > THRESH) ? 1'b1 : ((w_x < L_NEG_THRESH) ? 1'b0 : r_pos);
  assign w_rise    = w_pos_nxt & ~r_pos;
  assign w_period  = r_cnt + 12'd1;

  note_classifier u_classifier (
    .i_period (w_period),
    .o_class  (w_class)
  );

  always_comb begin
    w_stable_nxt = 8'd0;
    if (w_class != NOTE_NONE) begin
      if (w_class == r_note)
        w_stable_nxt = (r_stable < L_STABLE) ? r_stable + 8'd1 : L_STABLE;
      else
        w_stable_nxt = 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n || !enable) begin
      r_pos    <= 1'b0;
      r_armed  <= 1'b0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_pv     <= 1'b0;
      r_ps     <= '0;
      r_note   <= NOTE_NONE;
      r_nv     <= 1'b0;
    end else begin
      r_pv <= 1'b0;
      if (w_x_vld) begin
        r_pos <= w_pos_nxt;
        if (w_rise) begin
          r_cnt   <= '0;
          r_armed <= 1'b1;
          if (r_armed) begin
            r_pv     <= 1'b1;
            r_ps     <= w_period;
            r_note   <= w_class;
            r_stable <= w_stable_nxt;
            r_nv     <= (w_stable_nxt == L_STABLE);
          end
        end else begin
          if (r_cnt != L_MAX)
            r_cnt <= r_cnt + 12'd1;
          // Silence or an out-of-range tone: forget the note and re-arm
          if (r_cnt >= L_MAX_M1) begin
            r_armed  <= 1'b0;
            r_note   <= NOTE_NONE;
            r_nv     <= 1'b0;
            r_stable <= '0;
          end
        end
      end
    end
  end

  assign read_audio_in  = r_read;
  assign period_valid   = r_pv;
  assign period_samples = r_ps;
  assign note_index     = r_note;
  assign note_valid     = r_nv;

endmodule

// File: tb/tb_mic_tone_detector.sv
// tb/tb_mic_tone_detector.sv - randomized bench for mic_tone_detector against a per-sample behavioural model
module tb_mic_tone_detector;

  localparam longint THRESH = 1000000;
  localparam int     MAXP   = 400;
  localparam int     SC     = 3;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        audio_in_available = 1'b0;
  logic [31:0] left_channel_audio_in = '0;
  logic [31:0] right_channel_audio_in = '0;
  logic        read_audio_in;
  logic        period_valid;
  logic [11:0] period_samples;
  logic [2:0]  note_index;
  logic        note_valid;

  mic_tone_detector #(
    .THRESH       (32'sd1_000_000),
    .MAX_PERIOD   (MAXP),
    .STABLE_COUNT (SC)
  ) dut (
    .CLOCK_50               (CLOCK_50),
    .reset_n                (reset_n),
    .enable                 (enable),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .read_audio_in          (read_audio_in),
    .period_valid           (period_valid),
    .period_samples         (period_samples),
    .note_index             (note_index),
    .note_valid             (note_valid)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad = 0;
  int nprint = 0;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      if (nprint < 40) $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
      nprint++;
    end
  endtask

  // Stimulus waveform configuration (main process writes, driver reads)
  int     k = 0;
  int     w_k0 = 0;
  int     w_per = 92;
  longint w_amp = 0;
  int     noise = 0;
  int     avail_pct = 100;
  bit     raw = 1'b0;
  bit     rd_seen = 1'b0;

  function automatic int nz();
    if (noise == 0) return 0;
    return int'($urandom_range(0, 2 * noise)) - noise;
  endfunction

  initial begin : drv
    longint base;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (rd_seen) k++;
      rd_seen = read_audio_in;
      audio_in_available = (int'($urandom_range(0, 99)) < avail_pct);
      if (raw) begin
        left_channel_audio_in  = $urandom;
        right_channel_audio_in = $urandom;
      end else begin
        base = (((k - w_k0) % w_per) < (w_per / 2)) ? w_amp : -w_amp;
        left_channel_audio_in  = 32'(base + longint'(nz()));
        right_channel_audio_in = 32'(base + longint'(nz()));
      end
    end
  end

  // Behavioural model: one step per consumed sample
  int lo_b [7] = '{170, 147, 131, 120, 110, 98, 87};
  int hi_b [7] = '{195, 169, 146, 130, 119, 109, 97};

  function automatic int classify(input int per);
    for (int i = 0; i < 7; i++)
      if (per >= lo_b[i] && per <= hi_b[i]) return i + 1;
    return 0;
  endfunction

  bit     m_pos = 0, m_armed = 0;
  int     m_since = 0, m_stable = 0;
  bit     e_rd = 0, e_rd_prev = 0, e_pv = 0, e_nv = 0;
  int     e_ps = 0, e_ni = 0;
  bit     n_rd = 0, n_pv = 0, n_nv = 0;
  int     n_ps = 0, n_ni = 0;
  bit     s_read = 0;
  longint s_mono = 0;

  task automatic model_clear();
    m_pos = 0; m_armed = 0; m_since = 0; m_stable = 0;
    n_pv = 0; n_ps = 0; n_ni = 0; n_nv = 0;
  endtask

  task automatic model_step(input longint mono);
    bit np;
    int per, c;
    np = (mono > THRESH) ? 1'b1 : ((mono < -THRESH) ? 1'b0 : m_pos);
    if (np && !m_pos) begin
      if (m_armed) begin
        per = m_since + 1;
        c = classify(per);
        if (c != 0 && c == n_ni) m_stable = (m_stable < SC) ? m_stable + 1 : SC;
        else m_stable = (c != 0) ? 1 : 0;
        n_ni = c; n_nv = (m_stable == SC); n_ps = per; n_pv = 1;
      end
      m_armed = 1; m_since = 0;
    end else begin
      m_since++;
      if (m_since >= MAXP) begin
        m_armed = 0; n_ni = 0; n_nv = 0; m_stable = 0;
      end
    end
    m_pos = np;
  endtask

  initial forever begin
    @(negedge CLOCK_50);
    e_pv = n_pv; e_ps = n_ps; e_ni = n_ni; e_nv = n_nv;
    e_rd_prev = e_rd; e_rd = n_rd;
    if (!reset_n) begin
      e_pv = 0; e_ps = 0; e_ni = 0; e_nv = 0; e_rd = 0; e_rd_prev = 0;
    end
    chk("read_strobe", read_audio_in, e_rd);
    chk("period_valid", period_valid, e_pv);
    chk("period_samples", period_samples, e_ps);
    chk("note_index", note_index, e_ni);
    chk("note_valid", note_valid, e_nv);
    n_pv = 0; n_ps = e_ps; n_ni = e_ni; n_nv = e_nv;
    n_rd = reset_n && audio_in_available && enable && !e_rd && !e_rd_prev;
    if (!reset_n || !enable) model_clear();
    else if (s_read) model_step(s_mono);
    s_read = reset_n && e_rd;
    s_mono = (longint'($signed(left_channel_audio_in)) + longint'($signed(right_channel_audio_in))) >>> 1;
  end

  task automatic wait_rep(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLOCK_50);
      if (period_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  longint amps [4] = '{100000000, 2000000000, 3000000, 500000};

  initial begin : main
    bit ok;
    int n, last, gap_bad, pvc, kstart, reps, len;
    #15;
    chk("rst_read", read_audio_in, 0);
    chk("rst_pvalid", period_valid, 0);
    chk("rst_psamples", period_samples, 0);
    chk("rst_note", note_index, 0);
    chk("rst_nvalid", note_valid, 0);
    @(posedge CLOCK_50); #2 reset_n = 1; enable = 1;

    // Continuous availability: one-cycle strobe every third cycle
    repeat (6) @(negedge CLOCK_50);
    n = 0; last = -1; gap_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      if (read_audio_in) begin
        if (last >= 0 && i - last != 3) gap_bad++;
        last = i; n++;
      end
    end
    chk("cadence_count", n, 10);
    chk("cadence_gap", gap_bad, 0);

    // 92-sample square wave: C5, valid on third report
    avail_pct = 85; noise = 100000; w_amp = 100000000; w_per = 92; w_k0 = k;
    for (int r = 1; r <= 3; r++) begin
      wait_rep(ok);
      chk("p92_seen", ok, 1);
      chk("p92_psamples", period_samples, 92);
      chk("p92_note", note_index, 7);
      chk("p92_nvalid", note_valid, (r == 3) ? 1 : 0);
    end

    // Seamless switch to 184 at the edge just reported
    w_k0 = w_k0 + ((k - w_k0) / 92) * 92; w_per = 184;
    for (int r = 1; r <= 3; r++) begin
      wait_rep(ok);
      chk("p184_seen", ok, 1);
      chk("p184_psamples", period_samples, 184);
      chk("p184_note", note_index, 1);
      chk("p184_nvalid", note_valid, (r == 3) ? 1 : 0);
    end

    // Amplitude inside the hysteresis band: timeout, no reports
    w_amp = 500000; noise = 0; avail_pct = 100; kstart = k; pvc = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLOCK_50);
      if (period_valid) pvc++;
      if (k >= kstart + 420) break;
    end
    chk("to_reached", (k >= kstart + 420) ? 1 : 0, 1);
    chk("to_no_reports", pvc, 0);
    chk("to_note", note_index, 0);
    chk("to_nvalid", note_valid, 0);

    // Out-of-band period 60
    w_amp = 100000000; noise = 100000; w_per = 60; w_k0 = k;
    wait_rep(ok);
    chk("p60_seen", ok, 1);
    chk("p60_psamples", period_samples, 60);
    chk("p60_note", note_index, 0);
    chk("p60_nvalid", note_valid, 0);

    // Back to C5 until valid, then drop enable
    w_per = 92; w_k0 = k; ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLOCK_50);
      if (note_valid) begin ok = 1; break; end
    end
    chk("p92b_nvalid", ok, 1);
    @(posedge CLOCK_50); #2 enable = 0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("dis_pvalid", period_valid, 0);
    chk("dis_psamples", period_samples, 0);
    chk("dis_note", note_index, 0);
    chk("dis_nvalid", note_valid, 0);
    repeat (8) @(negedge CLOCK_50);
    w_k0 = k - 46;
    @(posedge CLOCK_50); #2 enable = 1;

    // First edge after re-enable only arms: valid on the third report
    reps = 0;
    for (int r = 0; r < 6; r++) begin
      wait_rep(ok);
      if (!ok) break;
      reps++;
      if (reps == 1) chk("re_first_psamples", period_samples, 92);
      if (note_valid) break;
    end
    chk("re_reports_to_valid", reps, 3);

    // Asynchronous reset while valid: outputs drop at once
    @(posedge CLOCK_50); #2 reset_n = 0;
    #1;
    chk("arst_read", read_audio_in, 0);
    chk("arst_pvalid", period_valid, 0);
    chk("arst_psamples", period_samples, 0);
    chk("arst_note", note_index, 0);
    chk("arst_nvalid", note_valid, 0);
    repeat (3) @(negedge CLOCK_50);
    @(posedge CLOCK_50); #2 reset_n = 1;

    // Randomized segments checked by the model
    for (int seg = 0; seg < 6; seg++) begin
      raw = ($urandom_range(0, 3) == 0);
      w_per = int'($urandom_range(50, 230));
      w_amp = amps[$urandom_range(0, 3)];
      noise = int'($urandom_range(0, 200000));
      avail_pct = int'($urandom_range(60, 100));
      w_k0 = k;
      len = int'($urandom_range(600, 1400));
      for (int i = 0; i < len; i++) begin
        @(negedge CLOCK_50);
        if (i == len / 2 && $urandom_range(0, 2) == 0) begin
          @(posedge CLOCK_50); #2 enable = 0;
          repeat ($urandom_range(1, 6)) @(negedge CLOCK_50);
          @(posedge CLOCK_50); #2 enable = 1;
        end
      end
    end
    raw = 0;
    repeat (4) @(negedge CLOCK_50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
